dbg_xact_sched: RTL and testbench

//  Sequences single SWD transactions into dbgIF's command/go/done port on behalf of one upstream requester.

---
 rtl/dbg_xact_sched.sv | 165 ++++++++++++++++
 tb/tb_dbg_xact_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_xact_sched.sv
// dbg_xact_sched: runs one SWD transaction through dbgIF per upstream
// request, retrying WAIT acks after a programmable backoff.
module dbg_xact_sched #(
  parameter logic [3:0] CMD_TRANSACT = 4'd8,
  parameter int         RETRY_W      = 8,
  parameter int         BACKOFF_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_addr32,
  input  logic                 req_rnw,
  input  logic                 req_apndp,
  input  logic [31:0]          req_wdata,
  input  logic [RETRY_W-1:0]   retry_max,
  input  logic [BACKOFF_W-1:0] backoff,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_ack,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_perr,
  output logic                 rsp_timeout,
  output logic [RETRY_W-1:0]   rsp_retries,
  output logic                 busy,
  output logic [1:0]           dbg_addr32,
  output logic                 dbg_rnw,
  output logic                 dbg_apndp,
  output logic [31:0]          dbg_dwrite,
  output logic [3:0]           dbg_command,
  output logic                 dbg_go,
  input  logic                 dbg_done,
  input  logic [2:0]           dbg_ack,
  input  logic [31:0]          dbg_dread,
  input  logic                 dbg_perr
);

  localparam logic [2:0] ACK_WAIT = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_EVAL,
    S_BACKOFF,
    S_RESP
  } state_t;

  state_t               state;
  logic [RETRY_W-1:0]   retry_max_q;
  logic [BACKOFF_W-1:0] backoff_q;
  logic [BACKOFF_W-1:0] bo_cnt;
  logic [2:0]           ack_q;
  logic [31:0]          dread_q;
  logic                 perr_q;
  logic                 is_wait;
  logic                 can_retry;

  // A parity error poisons the ack, so it never triggers a retry.
  assign is_wait   = !perr_q && (ack_q == ACK_WAIT);
  assign can_retry = is_wait && (rsp_retries < retry_max_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_ack     <= 3'b000;
      rsp_rdata   <= 32'd0;
      rsp_perr    <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_retries <= '0;
      dbg_addr32  <= 2'b00;
      dbg_rnw     <= 1'b0;
      dbg_apndp   <= 1'b0;
      dbg_dwrite  <= 32'd0;
      dbg_command <= 4'd0;
      dbg_go      <= 1'b0;
      retry_max_q <= '0;
      backoff_q   <= '0;
      bo_cnt      <= '0;
      ack_q       <= 3'b000;
      dread_q     <= 32'd0;
      perr_q      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            dbg_addr32  <= req_addr32;
            dbg_rnw     <= req_rnw;
            dbg_apndp   <= req_apndp;
            dbg_dwrite  <= req_wdata;
            retry_max_q <= retry_max;
            backoff_q   <= backoff;
            rsp_retries <= '0;
            rsp_ack     <= 3'b000;
            rsp_rdata   <= 32'd0;
            rsp_perr    <= 1'b0;
            rsp_timeout <= 1'b0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            dbg_go      <= 1'b1;
            dbg_command <= CMD_TRANSACT;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Hold go until dbgIF drops done to show it took the command.
          if (!dbg_done) begin
            dbg_go      <= 1'b0;
            dbg_command <= 4'd0;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (dbg_done) begin
            ack_q   <= dbg_ack;
            dread_q <= dbg_dread;
            perr_q  <= dbg_perr;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (can_retry) begin
            rsp_retries <= rsp_retries + RETRY_W'(1);
            bo_cnt      <= backoff_q;
            state       <= S_BACKOFF;
          end else begin
            rsp_ack     <= ack_q;
            rsp_rdata   <= dbg_rnw ? dread_q : 32'd0;
            rsp_perr    <= perr_q;
            rsp_timeout <= is_wait;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_BACKOFF: begin
          if (bo_cnt == '0) begin
            dbg_go      <= 1'b1;
            dbg_command <= CMD_TRANSACT;
            state       <= S_ISSUE;
          end else begin
            bo_cnt <= bo_cnt - BACKOFF_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          dbg_go    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_xact_sched.sv
// tb_dbg_xact_sched: directed bench for dbg_xact_sched with a small
// behavioural dbgIF that returns scripted WAIT/OK/FAULT acks.
module tb_dbg_xact_sched;

  logic        tck_swclk_tb;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_addr32;
  logic        req_rnw;
  logic        req_apndp;
  logic [31:0] req_wdata;
  logic [7:0]  retry_max;
  logic [15:0] backoff;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_perr;
  logic        rsp_timeout;
  logic [7:0]  rsp_retries;
  logic        busy;
  logic [1:0]  dbg_addr32;
  logic        dbg_rnw;
  logic        dbg_apndp;
  logic [31:0] dbg_dwrite;
  logic [3:0]  dbg_command;
  logic        dbg_go;
  logic        dbg_done;
  logic [2:0]  dbg_ack;
  logic [31:0] dbg_dread;
  logic        dbg_perr;

  dbg_xact_sched dut (
    .clk         (tck_swclk_tb),
    .rst         (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr32  (req_addr32),
    .req_rnw     (req_rnw),
    .req_apndp   (req_apndp),
    .req_wdata   (req_wdata),
    .retry_max   (retry_max),
    .backoff     (backoff),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_ack     (rsp_ack),
    .rsp_rdata   (rsp_rdata),
    .rsp_perr    (rsp_perr),
    .rsp_timeout (rsp_timeout),
    .rsp_retries (rsp_retries),
    .busy        (busy),
    .dbg_addr32  (dbg_addr32),
    .dbg_rnw     (dbg_rnw),
    .dbg_apndp   (dbg_apndp),
    .dbg_dwrite  (dbg_dwrite),
    .dbg_command (dbg_command),
    .dbg_go      (dbg_go),
    .dbg_done    (dbg_done),
    .dbg_ack     (dbg_ack),
    .dbg_dread   (dbg_dread),
    .dbg_perr    (dbg_perr)
  );

  initial tck_swclk_tb = 1'b0;
  always #5 tck_swclk_tb = ~tck_swclk_tb;

  // dbgIF model: first m_nwait attempts answer WAIT, then m_ack.
  int          m_dur;
  int          m_nwait;
  int          m_base;
  int          m_att;
  int          m_cnt;
  logic [2:0]  m_ack;
  logic [31:0] m_data;
  logic        m_perr;

  always @(posedge tck_swclk_tb or negedge rst_n) begin
    if (!rst_n) begin
      dbg_done  <= 1'b1;
      dbg_ack   <= 3'b000;
      dbg_dread <= 32'd0;
      dbg_perr  <= 1'b0;
      m_cnt     <= 0;
      m_att     <= 0;
    end else if (dbg_done && dbg_go) begin
      dbg_done <= 1'b0;
      m_cnt    <= m_dur;
    end else if (!dbg_done) begin
      if (m_cnt == 0) begin
        dbg_done  <= 1'b1;
        dbg_ack   <= ((m_att - m_base) < m_nwait) ? 3'b010 : m_ack;
        dbg_dread <= m_data;
        dbg_perr  <= m_perr;
        m_att     <= m_att + 1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int          pulses;
  int          min_gap;
  logic [31:0] run_dwrite;

  task automatic set_model(input int nwait, input logic [2:0] ack,
                           input logic [31:0] data, input logic perr);
    m_base  = m_att;
    m_nwait = nwait;
    m_ack   = ack;
    m_data  = data;
    m_perr  = perr;
  endtask

  task automatic send(input logic [1:0] a, input logic rnw,
                      input logic ap, input logic [31:0] wd,
                      input logic [7:0] rm, input logic [15:0] bo);
    int n;
    @(negedge tck_swclk_tb);
    req_addr32 = a;
    req_rnw    = rnw;
    req_apndp  = ap;
    req_wdata  = wd;
    retry_max  = rm;
    backoff    = bo;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge tck_swclk_tb);
      n++;
    end
    if (!req_ready) chk("req_ready_wait", 0, 1);
    @(negedge tck_swclk_tb);
    req_valid = 1'b0;
    retry_max = 8'hff;
    backoff   = 16'hffff;
  endtask

  task automatic wait_rsp();
    int   n;
    int   gap;
    logic prev;
    pulses  = 0;
    min_gap = 99999;
    gap     = 0;
    prev    = 1'b0;
    n       = 0;
    while (!rsp_valid && n < 2000) begin
      if (dbg_go && !prev) begin
        if (pulses > 0 && gap < min_gap) min_gap = gap;
        pulses++;
        gap = 0;
      end
      if (!dbg_go) gap++;
      if (!dbg_go && prev) run_dwrite = dbg_dwrite;
      prev = dbg_go;
      @(negedge tck_swclk_tb);
      n++;
    end
    if (!rsp_valid) chk("rsp_valid_wait", 0, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge tck_swclk_tb);
    rsp_ready = 1'b0;
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr32 = 2'b00;
    req_rnw    = 1'b0;
    req_apndp  = 1'b0;
    req_wdata  = 32'd0;
    retry_max  = 8'd0;
    backoff    = 16'd0;
    rsp_ready  = 1'b0;
    run_dwrite = 32'd0;
    m_dur      = 2;
    set_model(0, 3'b001, 32'd0, 1'b0);
    repeat (3) @(negedge tck_swclk_tb);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_go", 32'(dbg_go), 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    @(negedge tck_swclk_tb);

    // 1: plain read
    set_model(0, 3'b001, 32'habcdef12, 1'b0);
    send(2'd1, 1'b1, 1'b1, 32'd0, 8'd3, 16'd2);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_cmd", 32'(dbg_command), 8);
    chk("t1_addr", 32'(dbg_addr32), 1);
    wait_rsp();
    chk("t1_pulses", pulses, 1);
    chk("t1_ack", 32'(rsp_ack), 1);
    chk("t1_rdata", rsp_rdata, 32'habcdef12);
    chk("t1_retries", 32'(rsp_retries), 0);
    chk("t1_timeout", 32'(rsp_timeout), 0);
    chk("t1_perr", 32'(rsp_perr), 0);
    take_rsp();
    chk("t1_rsp_clr", 32'(rsp_valid), 0);
    chk("t1_ready", 32'(req_ready), 1);

    // 2: write
    set_model(0, 3'b001, 32'h5555aaaa, 1'b0);
    send(2'd2, 1'b0, 1'b0, 32'habcdef12, 8'd3, 16'd2);
    wait_rsp();
    chk("t2_dwrite", run_dwrite, 32'habcdef12);
    chk("t2_rdata", rsp_rdata, 0);
    chk("t2_ack", 32'(rsp_ack), 1);
    take_rsp();

    // 3: two WAITs then OK with backoff 5
    set_model(2, 3'b001, 32'h12345678, 1'b0);
    send(2'd0, 1'b1, 1'b1, 32'd0, 8'd3, 16'd5);
    wait_rsp();
    chk("t3_pulses", pulses, 3);
    chk("t3_gap", 32'(min_gap >= 8), 1);
    chk("t3_retries", 32'(rsp_retries), 2);
    chk("t3_ack", 32'(rsp_ack), 1);
    chk("t3_timeout", 32'(rsp_timeout), 0);
    take_rsp();

    // 4: WAIT forever, retry_max 2
    set_model(1000, 3'b001, 32'd0, 1'b0);
    send(2'd3, 1'b1, 1'b0, 32'd0, 8'd2, 16'd0);
    wait_rsp();
    chk("t4_pulses", pulses, 3);
    chk("t4_timeout", 32'(rsp_timeout), 1);
    chk("t4_ack", 32'(rsp_ack), 2);
    chk("t4_retries", 32'(rsp_retries), 2);
    take_rsp();

    // 4b: retry_max 0 disables retries
    set_model(1000, 3'b001, 32'd0, 1'b0);
    send(2'd3, 1'b1, 1'b0, 32'd0, 8'd0, 16'd0);
    wait_rsp();
    chk("t4b_pulses", pulses, 1);
    chk("t4b_timeout", 32'(rsp_timeout), 1);
    take_rsp();

    // 5: parity error, then FAULT
    set_model(0, 3'b001, 32'h0f0f0f0f, 1'b1);
    send(2'd1, 1'b1, 1'b1, 32'd0, 8'd3, 16'd1);
    wait_rsp();
    chk("t5_pulses", pulses, 1);
    chk("t5_perr", 32'(rsp_perr), 1);
    take_rsp();
    set_model(0, 3'b100, 32'h0, 1'b0);
    send(2'd1, 1'b0, 1'b1, 32'h1, 8'd3, 16'd1);
    wait_rsp();
    chk("t5_fault_pulses", pulses, 1);
    chk("t5_fault_ack", 32'(rsp_ack), 4);
    chk("t5_fault_retries", 32'(rsp_retries), 0);
    take_rsp();

    // 6: response back-pressure, then reset during RUN
    set_model(0, 3'b001, 32'hcafef00d, 1'b0);
    send(2'd2, 1'b1, 1'b0, 32'd0, 8'd3, 16'd1);
    wait_rsp();
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge tck_swclk_tb);
      chk("t6_hold_valid", 32'(rsp_valid), 1);
      chk("t6_hold_rdata", rsp_rdata, 32'hcafef00d);
      chk("t6_hold_ready", 32'(req_ready), 0);
    end
    req_valid = 1'b0;
    take_rsp();
    chk("t6_after_rsp", 32'(rsp_valid), 0);

    m_dur = 20;
    set_model(0, 3'b001, 32'h1, 1'b0);
    send(2'd3, 1'b0, 1'b1, 32'h77777777, 8'd3, 16'd1);
    for (int i = 0; i < 50 && dbg_go; i++) @(negedge tck_swclk_tb);
    repeat (3) @(negedge tck_swclk_tb);
    chk("t6_in_run", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_go", 32'(dbg_go), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_ready", 32'(req_ready), 1);
    chk("t6_rst_rsp", 32'(rsp_valid), 0);
    chk("t6_rst_dwrite", dbg_dwrite, 0);
    @(negedge tck_swclk_tb);
    rst_n = 1'b1;
    @(negedge tck_swclk_tb);
    chk("t6_post_ready", 32'(req_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
